// File: rtl/draw_pkg.sv
// Shared types and constants for the drawing-instruction sequencer.
// Optional feature macro used by draw_sequencer: DRAW_SEQ_LOOP_EN.
package draw_pkg;

    localparam int PC_W    = 8;
    localparam int COORD_W = 10;
    localparam int COLOR_W = 3;

    // Sequencer control states, also exported on the debug state port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLOT  = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

    // One pixel write toward the framebuffer.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } pixel_t;

endpackage

// File: rtl/line_stepper.sv
// Combinational Chebyshev stepper: moves each axis one unit toward the
// target when it differs, and flags when the source already sits on it.
module line_stepper #(
    parameter int COORD_W = draw_pkg::COORD_W
) (
    input  logic [COORD_W-1:0] cur_x_i,
    input  logic [COORD_W-1:0] cur_y_i,
    input  logic [COORD_W-1:0] tgt_x_i,
    input  logic [COORD_W-1:0] tgt_y_i,
    output logic [COORD_W-1:0] nxt_x_o,
    output logic [COORD_W-1:0] nxt_y_o,
    output logic               at_target_o
);

    localparam logic [COORD_W-1:0] ONE = {{(COORD_W-1){1'b0}}, 1'b1};

    // Steps only ever approach the target, so neither add nor subtract can wrap.
    always_comb begin
        nxt_x_o = cur_x_i;
        nxt_y_o = cur_y_i;
        if (cur_x_i < tgt_x_i) begin
            nxt_x_o = cur_x_i + ONE;
        end else if (cur_x_i > tgt_x_i) begin
            nxt_x_o = cur_x_i - ONE;
        end
        if (cur_y_i < tgt_y_i) begin
            nxt_y_o = cur_y_i + ONE;
        end else if (cur_y_i > tgt_y_i) begin
            nxt_y_o = cur_y_i - ONE;
        end
        at_target_o = (cur_x_i == tgt_x_i) && (cur_y_i == tgt_y_i);
    end

endmodule

// File: rtl/draw_sequencer.sv
// Instruction fetch-and-plot engine: walks a polyline stored in a
// combinational ROM, one pixel per accepted beat.
// Optional feature macro: DRAW_SEQ_LOOP_EN (loop back to instruction 0 and
// close the polygon instead of stopping in DONE).
//
// Pixel port handshake: a beat transfers on a rising edge where pix_valid
// and pix_ready are both high; once pix_valid is raised, pix_x/pix_y/
// pix_color hold until that transfer, and pix_valid never looks at
// pix_ready combinationally.
module draw_sequencer #(
    parameter int PROG_LEN = 3,
    parameter int COORD_W  = draw_pkg::COORD_W,
    parameter int COLOR_W  = draw_pkg::COLOR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [draw_pkg::PC_W-1:0]     pc,
    input  logic [COORD_W-1:0]            next_x,
    input  logic [COORD_W-1:0]            next_y,
    input  logic [COLOR_W-1:0]            ch,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [COORD_W-1:0]            pix_x,
    output logic [COORD_W-1:0]            pix_y,
    output logic [COLOR_W-1:0]            pix_color,
    output logic                          busy,
    output logic                          done,
    output draw_pkg::draw_state_t         dbg_state
);

    import draw_pkg::*;

`ifdef DRAW_SEQ_LOOP_EN
    localparam bit LOOP_EN = 1'b1;
`else
    localparam bit LOOP_EN = 1'b0;
`endif

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    draw_state_t        state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [COLOR_W-1:0] col_q, col_d, pix_color_q, pix_color_d;
    logic               first_q, first_d;
    logic               pix_valid_q, pix_valid_d;
    logic               busy_q, busy_d, done_q, done_d;

    logic               accept;
    logic               last_instr;
    logic [COORD_W-1:0] step_src_x, step_src_y, step_dst_x, step_dst_y;
    logic [COORD_W-1:0] step_x, step_y;
    logic               step_at_tgt;

    assign accept     = (state_q == PLOT) && pix_valid_q && pix_ready;
    assign last_instr = (pc_q == LAST_PC);

    // In FETCH the first beat is stepped from the cursor toward the live ROM
    // target; in PLOT the next beat is stepped from the beat being accepted.
    assign step_src_x = (state_q == PLOT)  ? pix_x_q : cur_x_q;
    assign step_src_y = (state_q == PLOT)  ? pix_y_q : cur_y_q;
    assign step_dst_x = (state_q == FETCH) ? next_x  : tgt_x_q;
    assign step_dst_y = (state_q == FETCH) ? next_y  : tgt_y_q;

    line_stepper #(.COORD_W(COORD_W)) u_stepper (
        .cur_x_i     (step_src_x),
        .cur_y_i     (step_src_y),
        .tgt_x_i     (step_dst_x),
        .tgt_y_i     (step_dst_y),
        .nxt_x_o     (step_x),
        .nxt_y_o     (step_y),
        .at_target_o (step_at_tgt)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a segment ends when the accepted beat is the target.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = FETCH;
            FETCH:      state_d = PLOT;
            PLOT: begin
                if (accept && step_at_tgt) begin
                    state_d = (last_instr && !LOOP_EN) ? DONE : FETCH;
                end
            end
            default:    state_d = IDLE;
        endcase
    end

    // Datapath next values: pc, cursor, latched instruction and the beat.
    always_comb begin
        pc_d        = pc_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        tgt_x_d     = tgt_x_q;
        tgt_y_d     = tgt_y_q;
        col_d       = col_q;
        first_d     = first_q;
        pix_valid_d = pix_valid_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        pix_color_d = pix_color_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    pc_d    = '0;
                    first_d = 1'b1;
                end
            end
            FETCH: begin
                tgt_x_d     = next_x;
                tgt_y_d     = next_y;
                col_d       = ch;
                pix_valid_d = 1'b1;
                pix_x_d     = first_q ? next_x : step_x;
                pix_y_d     = first_q ? next_y : step_y;
                pix_color_d = ch;
            end
            PLOT: begin
                if (accept) begin
                    cur_x_d = pix_x_q;
                    cur_y_d = pix_y_q;
                    first_d = 1'b0;
                    if (step_at_tgt) begin
                        pix_valid_d = 1'b0;
                        if (!last_instr) begin
                            pc_d = pc_q + PC_ONE;
                        end else if (LOOP_EN) begin
                            pc_d = '0;
                        end
                    end else begin
                        pix_x_d = step_x;
                        pix_y_d = step_y;
                    end
                end
            end
            default: pix_valid_d = 1'b0;
        endcase
        busy_d = (state_d == FETCH) || (state_d == PLOT);
        done_d = (state_d == DONE);
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            tgt_x_q     <= '0;
            tgt_y_q     <= '0;
            col_q       <= '0;
            first_q     <= 1'b1;
            pix_valid_q <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_color_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            tgt_x_q     <= tgt_x_d;
            tgt_y_q     <= tgt_y_d;
            col_q       <= col_d;
            first_q     <= first_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_color_q <= pix_color_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign pc        = pc_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Instruction fetch-and-plot engine consuming the combinational drawing-instruction ROM. It drives `pc`, latches each returned `{next_x, next_y, ch}` and walks a cursor from its current position to the target one pixel per accepted beat. Every pixel goes out on a valid/ready pixel-write port toward the framebuffer writer. The result is a polyline: the first instruction positions the cursor, and each later instruction draws a segment in colour `ch`.

## Interface
Parameters:
- `PROG_LEN`, 3: number of instructions executed, pc 0..PROG_LEN-1; legal range 1..256.
- `COORD_W`, 10: coordinate width.
- `COLOR_W`, 3: colour width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle pulse; honoured only in IDLE or DONE.
- `pc`  out  8  registered instruction address to the ROM.
- `next_x`  in  COORD_W  ROM target x, combinational from `pc`.
- `next_y`  in  COORD_W  ROM target y.
- `ch`  in  COLOR_W  ROM colour.
- `pix_valid`  out  1  pixel-write request.
- `pix_ready`  in  1  framebuffer accepts the beat when high with `pix_valid`.
- `pix_x`, `pix_y`  out  COORD_W  pixel coordinates.
- `pix_color`  out  COLOR_W  pixel colour.
- `busy`  out  1  high in FETCH and PLOT.
- `done`  out  1  high in DONE.

## Operation
- States: IDLE, FETCH, PLOT, DONE.
- IDLE: `start` sets pc=0 and first=1, then goes to FETCH.
- FETCH, exactly 1 cycle: latch `tgt_x/tgt_y/col` from the ROM outputs, then go to PLOT.
- PLOT: present a beat.
  - If first=1, the beat is the target itself.
  - Otherwise each axis steps ±1 toward the target if it differs; if both axes are equal, the beat is the cursor itself. This is Chebyshev stepping, not Bresenham.
  - `pix_color`=col.
- Each beat is accepted when `pix_valid && pix_ready`. On acceptance, cursor := beat position and first := 0.
  - If the beat equals the target, the segment ends. If pc==PROG_LEN-1, go to DONE; else pc+1 and go to FETCH.
  - Otherwise stay in PLOT and present the next step.
- Segment pixel count = max(|dx|,|dy|). The start pixel is excluded and the endpoint is included. A zero-length segment emits exactly 1 pixel at the target.
- DONE: hold the cursor. `start` sets pc=0 and first=1, then goes to FETCH.
- `start` is ignored in FETCH and PLOT.
- Arithmetic: unsigned COORD_W compares. Steps always move toward the target, so no wrap is possible.

## Timing
- Reset values (synchronous, `rst_n`=0 at the edge): state IDLE, pc=0, cursor=(0,0), tgt=0, col=0, first=1, `pix_valid`=0, `pix_x/pix_y/pix_color`=0, `busy`=0, `done`=0.
- `start` sampled at edge k: FETCH during cycle k+1, first `pix_valid` in cycle k+2.
- Between segments there is one FETCH bubble with `pix_valid`=0.
- Valid/ready rules:
  - Once `pix_valid` rises, `pix_x/pix_y/pix_color` stay stable until accepted.
  - `pix_valid` does not depend combinationally on `pix_ready`.
  - Back-to-back beats are allowed: one pixel per cycle with `pix_ready` held high.
- All outputs are registered.
- Reset during PLOT: `pix_valid`=0 from the next cycle. Any beat not yet accepted is dropped.

## Configuration
- `DRAW_SEQ_LOOP_EN` undefined: after the last segment, enter DONE, `done`=1, and wait for `start`.
- `DRAW_SEQ_LOOP_EN` defined: after the last segment, set pc=0 and first=0, then go to FETCH.
  - DONE is never entered and `done` stays 0.
  - Instruction 0 is drawn as a segment from the last endpoint, which closes the polygon.

## Structure
- Package `draw_pkg`:
  - state enum `draw_state_t` {IDLE, FETCH, PLOT, DONE};
  - constants `PC_W`=8, `COORD_W`=10, `COLOR_W`=3;
  - struct `pixel_t` {x, y, color}.
- Sub-module `line_stepper`: combinational; inputs cursor and target; outputs the next position and an `at_target` flag. It is instantiated once.

## Test plan
- ROM program (50,60,0) → (100,80,2) → (150,120,4), `pix_ready`=1, pulse `start`:
  - first beat is (50,60) with colour 0 in cycle k+2;
  - then 50 beats of colour 2 ending at (100,80);
  - then 50 beats of colour 4 ending at (150,120);
  - 101 beats total; `done`=1; `pc`=2.
- Same program, `pix_ready` toggling pseudo-randomly: same 101-beat sequence; payload never changes while `pix_valid` is high and `pix_ready` is low.
- Zero-length segment, instruction 1 equal to (50,60): exactly 1 beat at (50,60), then FETCH for pc=2.
- `rst_n` low during the 10th beat of segment 1: next cycle `pix_valid`=0, state IDLE, `pc`=0, cursor (0,0); a new `start` replays from (50,60).
- `start` pulsed during PLOT is ignored (beat count unchanged); `start` in DONE replays all 101 beats.
- With `DRAW_SEQ_LOOP_EN`: after (150,120), 100 beats return to (50,60); `done` is never asserted.
